// File: rtl/imem_pkg.sv
// Shared definitions for the imem port arbiter: default BRAM geometry,
// arbiter state encoding and requester identifiers.
package imem_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DATA_W = 32;

  // ARB_LOCK: the loader owns the port until it drops l_lock
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_L = 1'b1
  } req_id_e;

endpackage

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares the single port of the imem block RAM between instruction fetch (F,
// read-only) and the loader/debug port (L, read/write). Grants are decided
// combinationally from the requests and the lock state; the read response comes
// back one cycle later on the owner's rvalid/rdata.
// Optional feature: define IMEM_ARB_RR_EN for round-robin arbitration between F
// and L; without it L has fixed priority over F.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              err,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);

  // A byte address maps into imem only if word aligned and inside the RAM.
  function automatic logic addr_in_range(input logic [31:0] addr);
    return ((addr >> (ADDR_W + 2)) == 32'd0) && (addr[1:0] == 2'b00);
  endfunction

  arb_state_e  state;
  logic        lock_hold;
  logic        l_pref;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic        sel_ok;

  // Response pipeline: one in-flight access, answered in the following cycle.
  logic        vld_p1;
  req_id_e     own_p1;
  logic        err_p1;
  logic        wr_p1;
  logic        rd_ok_p1;

  // The loader keeps the port only while it is locked and still asserting l_lock;
  // dropping l_lock hands arbitration back in the same cycle.
  assign lock_hold = (state == ARB_LOCK) && l_lock;

`ifdef IMEM_ARB_RR_EN
  req_id_e last_win;

  // On a conflict the requester that did not win last time goes first.
  assign l_pref = (last_win == REQ_F);
`else
  assign l_pref = 1'b1;
`endif

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rsta_n) begin
      if (lock_hold) begin
        l_gnt = l_req;
      end else if (l_req && (!f_req || l_pref)) begin
        l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
      end
    end
  end

  assign any_gnt  = f_gnt | l_gnt;
  assign sel_addr = l_gnt ? l_addr : f_addr;
  assign sel_ok   = addr_in_range(sel_addr);

  // BRAM port drive: out-of-range accesses are granted but never reach the RAM.
  always_comb begin
    ena   = any_gnt && sel_ok;
    wea   = l_gnt && l_we && sel_ok;
    addra = any_gnt ? sel_addr[ADDR_W+1:2] : '0;
    dina  = (l_gnt && l_we) ? l_wdata : '0;
  end

  // Arbiter FSM: enter ARB_LOCK when the loader is granted with l_lock set,
  // leave on the first cycle l_lock is low.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state <= ARB_IDLE;
`ifdef IMEM_ARB_RR_EN
      last_win <= REQ_L;
`endif
    end else begin
      if (l_l_lock_next()) begin
        state <= ARB_LOCK;
      end else begin
        state <= ARB_IDLE;
      end
`ifdef IMEM_ARB_RR_EN
      if (any_gnt) begin
        last_win <= l_gnt ? REQ_L : REQ_F;
      end
`endif
    end
  end

  function automatic logic l_l_lock_next();
    return l_lock && (lock_hold || l_gnt);
  endfunction

  // ---- stage p1: response of the access granted in the previous cycle ----
  // Reset drops any pending response so an abandoned BRAM cycle never answers.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      vld_p1 <= 1'b0;
      own_p1 <= REQ_F;
      err_p1 <= 1'b0;
      wr_p1  <= 1'b0;
    end else begin
      vld_p1 <= any_gnt;
      own_p1 <= l_gnt ? REQ_L : REQ_F;
      err_p1 <= any_gnt && !sel_ok;
      wr_p1  <= l_gnt && l_we;
    end
  end

  // Only a clean read forwards douta; write acks and errors return zero.
  assign rd_ok_p1 = vld_p1 && !err_p1 && !wr_p1;

  // Response outputs steered to the owner of the pending access.
  always_comb begin
    f_rvalid = vld_p1 && (own_p1 == REQ_F);
    l_rvalid = vld_p1 && (own_p1 == REQ_L);
    err      = vld_p1 && err_p1;
    f_rdata  = (rd_ok_p1 && (own_p1 == REQ_F)) ? douta : '0;
    l_rdata  = (rd_ok_p1 && (own_p1 == REQ_L)) ? douta : '0;
  end

endmodule
